// File: rtl/axi4_poly_scalar_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_poly_scalar_master
//  Purpose  : On each interconnect grant, reads NUM_COEF coefficients in one
//             AXI4 INCR burst, applies a scalar op (add/sub/mul/xor) to all
//             of them at once, writes them back in one INCR burst, checks the
//             write response and returns the grant.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module axi4_poly_scalar_master #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter int                ID_W     = 4,
    parameter int                NUM_COEF = 4,
    parameter logic [ADDR_W-1:0] RD_BASE  = '0,
    parameter logic [ADDR_W-1:0] WR_BASE  = '0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              SET_ACCESS,
    output logic              RELEASE_ACCESS,
    input  logic [1:0]        OP,
    input  logic [DATA_W-1:0] SCALAR,
    output logic              DONE,
    output logic              ERROR,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    // Beat indices need to represent NUM_COEF itself (up to 16) so that
    // surplus read beats can be recognised.
    localparam int                IDX_W      = 5;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_COEF - 1);
    localparam logic [IDX_W-1:0]  NUM_IDX    = IDX_W'(NUM_COEF);
    localparam logic [7:0]        BURST_LEN  = 8'(NUM_COEF - 1);
    localparam logic [2:0]        BURST_SIZE = (DATA_W == 32) ? 3'd2 :
                                               (DATA_W == 16) ? 3'd1 : 3'd0;
    localparam logic [1:0]        BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_CALC = 3'd3,
        S_AW   = 3'd4,
        S_W    = 3'd5,
        S_B    = 3'd6,
        S_REL  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  buf_q [NUM_COEF];
    logic [DATA_W-1:0]  buf_d [NUM_COEF];
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  scalar_q, scalar_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic               beat_err;
    logic [DATA_W-1:0]  wdata_sel;

    // Scalar operation, wrapping modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] apply_op(input logic [1:0]        op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            2'b00:   apply_op = a + b;
            2'b01:   apply_op = a - b;
            2'b10:   apply_op = prod[DATA_W-1:0];
            default: apply_op = a ^ b;
        endcase
    endfunction

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            scalar_q <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            k_q      <= '0;
            j_q      <= '0;
            for (int i = 0; i < NUM_COEF; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            scalar_q <= scalar_d;
            id_q     <= id_d;
            err_q    <= err_d;
            k_q      <= k_d;
            j_q      <= j_d;
            buf_q    <= buf_d;
        end
    end

    // Next-state logic: pass sequencing, beat capture, error detection.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        op_d     = op_q;
        scalar_d = scalar_q;
        id_d     = id_q;
        err_d    = err_q;
        k_d      = k_q;
        j_d      = j_q;
        beat_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (SET_ACCESS) begin
                    op_d     = OP;
                    scalar_d = SCALAR;
                    err_d    = 1'b0;
                    k_d      = '0;
                    j_d      = '0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                if (RVALID) begin
                    beat_err = (RRESP != 2'b00) || (RID != id_q) ||
                               (k_q >= NUM_IDX) || (RLAST && (k_q != LAST_IDX));
                    for (int i = 0; i < NUM_COEF; i++) begin
                        if (k_q == IDX_W'(i)) buf_d[i] = RDATA;
                    end
                    // Saturate so surplus beats keep flagging without wrapping.
                    if (k_q < NUM_IDX) k_d = k_q + IDX_W'(1);
                    if (beat_err) err_d = 1'b1;
                    if (RLAST) state_d = (err_q || beat_err) ? S_REL : S_CALC;
                end
            end
            S_CALC: begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    buf_d[i] = apply_op(op_q, buf_q[i], scalar_q);
                end
                state_d = S_AW;
            end
            S_AW: begin
                if (AWREADY) begin
                    j_d     = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (WREADY) begin
                    if (j_q == LAST_IDX) state_d = S_B;
                    else                 j_d     = j_q + IDX_W'(1);
                end
            end
            S_B: begin
                if (BVALID) begin
                    if ((BRESP != 2'b00) || (BID != id_q)) err_d = 1'b1;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                id_d    = id_q + ID_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-data mux over the coefficient buffer.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < NUM_COEF; i++) begin
            if (j_q == IDX_W'(i)) wdata_sel = buf_q[i];
        end
    end

    // All handshake outputs are decoded from the state register only, so no
    // VALID can depend on its READY. Address-channel fields are zero outside
    // their own phase, which also makes every output zero in reset.
    assign ARVALID        = (state_q == S_AR);
    assign ARID           = ARVALID ? id_q       : '0;
    assign ARADDR         = ARVALID ? RD_BASE    : '0;
    assign ARLEN          = ARVALID ? BURST_LEN  : '0;
    assign ARSIZE         = ARVALID ? BURST_SIZE : '0;
    assign ARBURST        = ARVALID ? BURST_INCR : '0;
    assign RREADY         = (state_q == S_R);
    assign AWVALID        = (state_q == S_AW);
    assign AWID           = AWVALID ? id_q       : '0;
    assign AWADDR         = AWVALID ? WR_BASE    : '0;
    assign AWLEN          = AWVALID ? BURST_LEN  : '0;
    assign AWSIZE         = AWVALID ? BURST_SIZE : '0;
    assign AWBURST        = AWVALID ? BURST_INCR : '0;
    assign WVALID         = (state_q == S_W);
    assign WDATA          = WVALID ? wdata_sel : '0;
    assign WLAST          = WVALID && (j_q == LAST_IDX);
    assign BREADY         = (state_q == S_B);
    assign RELEASE_ACCESS = (state_q == S_REL);
    assign DONE           = (state_q == S_REL);
    assign ERROR          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_poly_scalar_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_poly_scalar_master
//  Purpose  : Self-checking bench: table of directed passes against a small
//             AXI4 slave model, plus error, stall and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_poly_scalar_master;

    localparam int         DATA_W   = 8;
    localparam int         ADDR_W   = 5;
    localparam int         ID_W     = 4;
    localparam int         NUM_COEF = 4;
    localparam logic [4:0] RD_B     = 5'h04;
    localparam logic [4:0] WR_B     = 5'h10;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              SET_ACCESS;
    logic              RELEASE_ACCESS;
    logic [1:0]        OP;
    logic [DATA_W-1:0] SCALAR;
    logic              DONE, ERROR;
    logic [ID_W-1:0]   ARID, AWID, RID, BID;
    logic [ADDR_W-1:0] ARADDR, AWADDR;
    logic [7:0]        ARLEN, AWLEN;
    logic [2:0]        ARSIZE, AWSIZE;
    logic [1:0]        ARBURST, AWBURST, RRESP, BRESP;
    logic              ARVALID, ARREADY, AWVALID, AWREADY;
    logic [DATA_W-1:0] RDATA, WDATA;
    logic              RLAST, RVALID, RREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    axi4_poly_scalar_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_COEF(NUM_COEF),
        .RD_BASE(RD_B), .WR_BASE(WR_B)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .SET_ACCESS(SET_ACCESS),
        .RELEASE_ACCESS(RELEASE_ACCESS), .OP(OP), .SCALAR(SCALAR),
        .DONE(DONE), .ERROR(ERROR),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave configuration and observation ----------------
    logic [7:0]      mem [4];
    int              ar_delay, aw_delay, n_rbeats, rlast_at, rresp_err_at;
    bit              w_toggle, wtog_phase;
    logic [1:0]      bresp_cfg;
    bit              r_active, b_pending, w_stall;
    int              r_idx, ar_cnt, aw_cnt, w_cnt, aw_seen, ar_cycles;
    int              ar_bad, aw_bad, w_bad;
    int              cyc, rel_cnt, done_cnt, rel_at;
    logic [7:0]      wdata_log [8];
    logic [7:0]      wlast_bits;
    logic [7:0]      stall_wdata;
    logic            stall_wlast;
    logic [ID_W-1:0] cap_arid, cap_awid, exp_id;

    int n_cmp, n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: decides its inputs at each falling edge from stable DUT
    // outputs, so it knows which handshakes complete on the next rising edge.
    initial begin
        ARREADY = 0; RVALID = 0; RDATA = '0; RID = '0; RRESP = '0; RLAST = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BID = '0; BRESP = '0;
        forever begin
            @(negedge ACLK);
            cyc++;
            ARREADY = 0; RVALID = 0; RDATA = '0; RLAST = 0; RRESP = '0;
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
            if (!ARESET) begin
                r_active = 0; b_pending = 0; w_stall = 0;
                ar_cnt = 0; aw_cnt = 0; wtog_phase = 0;
            end else begin
                if (RELEASE_ACCESS) begin rel_cnt++; rel_at = cyc; end
                if (DONE) done_cnt++;
                // R channel
                if (r_active && r_idx < n_rbeats) begin
                    RVALID = 1;
                    RDATA  = (r_idx < 4) ? mem[r_idx] : 8'hEE;
                    RID    = cap_arid;
                    RRESP  = (r_idx == rresp_err_at) ? 2'b10 : 2'b00;
                    RLAST  = (r_idx == rlast_at);
                    if (RREADY) begin
                        r_idx++;
                        if (RLAST) r_active = 0;
                    end
                end
                // AR channel
                if (ARVALID) begin
                    ar_cycles++;
                    if (ARADDR != RD_B || ARLEN != 8'd3 || ARSIZE != 3'd0 ||
                        ARBURST != 2'b01 || ARID != exp_id) ar_bad++;
                    if (ar_cnt >= ar_delay) begin
                        ARREADY = 1; r_active = 1; r_idx = 0;
                        cap_arid = ARID; ar_cnt = 0;
                    end else ar_cnt++;
                end
                // B channel
                if (b_pending) begin
                    BVALID = 1; BID = cap_awid; BRESP = bresp_cfg;
                    if (BREADY) b_pending = 0;
                end
                // W channel, with hold-while-stalled check
                if (w_stall && (!WVALID || WDATA != stall_wdata || WLAST != stall_wlast)) w_bad++;
                w_stall = 0;
                if (WVALID) begin
                    WREADY = w_toggle ? wtog_phase : 1'b1;
                    wtog_phase = ~wtog_phase;
                    if (WREADY) begin
                        if (w_cnt < 8) begin
                            wdata_log[w_cnt]  = WDATA;
                            wlast_bits[w_cnt] = WLAST;
                        end
                        w_cnt++;
                        if (WLAST) b_pending = 1;
                    end else begin
                        w_stall = 1; stall_wdata = WDATA; stall_wlast = WLAST;
                    end
                end
                // AW channel
                if (AWVALID) begin
                    aw_seen++;
                    if (AWADDR != WR_B || AWLEN != 8'd3 || AWSIZE != 3'd0 ||
                        AWBURST != 2'b01 || AWID != exp_id) aw_bad++;
                    if (aw_cnt >= aw_delay) begin
                        AWREADY = 1; cap_awid = AWID; aw_cnt = 0;
                    end else aw_cnt++;
                end
            end
        end
    end

    // ---------------- pass helpers ----------------
    int g, rel0, done0;

    task automatic start_grant(input logic [1:0] op, input logic [7:0] sc);
        @(negedge ACLK); #1;
        w_cnt = 0; aw_seen = 0; ar_cycles = 0; ar_bad = 0; aw_bad = 0; w_bad = 0;
        wlast_bits = '0; wtog_phase = 0;
        for (int i = 0; i < 8; i++) wdata_log[i] = 8'h00;
        rel0 = rel_cnt; done0 = done_cnt;
        OP = op; SCALAR = sc; SET_ACCESS = 1; g = cyc;
        @(negedge ACLK); #1;
        SET_ACCESS = 0; OP = ~op; SCALAR = ~sc;   // must not disturb this pass
        chk("arvalid_after_grant", 64'(ARVALID), 64'd1);
        chk("error_cleared_on_grant", 64'(ERROR), 64'd0);
    endtask

    task automatic wait_release();
        int t;
        t = 0;
        while (rel_cnt == rel0 && t < 300) begin @(negedge ACLK); #1; t++; end
        chk("release_seen", 64'(rel_cnt != rel0), 64'd1);
        repeat (3) @(negedge ACLK);
        #1;
        chk("release_pulses", 64'(rel_cnt - rel0), 64'd1);
        chk("done_pulses", 64'(done_cnt - done0), 64'd1);
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [7:0]      scalar;
        int              ar_dly;
        int              aw_dly;
        bit              wtog;
        logic [3:0][7:0] exp;      // {beat3, beat2, beat1, beat0}
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input string tag);
        ar_delay = v.ar_dly; aw_delay = v.aw_dly; w_toggle = v.wtog;
        start_grant(v.op, v.scalar);
        wait_release();
        for (int b = 0; b < 4; b++)
            chk({tag, "_wdata"}, 64'(wdata_log[b]), 64'(v.exp[b]));
        chk({tag, "_wbeats"}, 64'(w_cnt), 64'd4);
        chk({tag, "_wlast"}, 64'(wlast_bits[3:0]), 64'h8);
        chk({tag, "_error"}, 64'(ERROR), 64'd0);
        chk({tag, "_arid"}, 64'(cap_arid), 64'(exp_id));
        chk({tag, "_awid"}, 64'(cap_awid), 64'(exp_id));
        chk({tag, "_fields_stable"}, 64'(ar_bad + aw_bad + w_bad), 64'd0);
        if (v.ar_dly > 0)
            chk({tag, "_arvalid_held"}, 64'(ar_cycles), 64'(v.ar_dly + 1));
        if (v.aw_dly > 0)
            chk({tag, "_awvalid_held"}, 64'(aw_seen), 64'(v.aw_dly + 1));
        // Cycle n spans rising edges n-1..n, counting the grant edge as 0.
        if (v.ar_dly == 0 && v.aw_dly == 0 && !v.wtog)
            chk({tag, "_release_latency"}, 64'(rel_at - g), 64'(2 * NUM_COEF + 5));
        exp_id = exp_id + 4'd1;
    endtask

    task automatic run_err_pass(input string tag);
        ar_delay = 0; aw_delay = 0; w_toggle = 0;
        start_grant(2'b00, 8'h02);
        wait_release();
        chk({tag, "_error"}, 64'(ERROR), 64'd1);
        chk({tag, "_no_awvalid"}, 64'(aw_seen), 64'd0);
        chk({tag, "_no_wbeats"}, 64'(w_cnt), 64'd0);
        exp_id = exp_id + 4'd1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; exp_id = '0;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hFF;
        ar_delay = 0; aw_delay = 0; w_toggle = 0; n_rbeats = 4; rlast_at = 3;
        rresp_err_at = -1; bresp_cfg = 2'b00;
        ARESET = 0; SET_ACCESS = 0; OP = 2'b00; SCALAR = '0;

        //             op     scalar ar aw tog  expected {b3,b2,b1,b0}
        vecs[0] = '{2'b00, 8'h02, 0, 0, 0, {8'h01, 8'h32, 8'h22, 8'h12}};
        vecs[1] = '{2'b01, 8'h11, 0, 0, 0, {8'hEE, 8'h1F, 8'h0F, 8'hFF}};
        vecs[2] = '{2'b10, 8'h03, 0, 0, 0, {8'hFD, 8'h90, 8'h60, 8'h30}};
        vecs[3] = '{2'b11, 8'h0F, 0, 0, 0, {8'hF0, 8'h3F, 8'h2F, 8'h1F}};
        vecs[4] = '{2'b00, 8'h02, 3, 3, 1, {8'h01, 8'h32, 8'h22, 8'h12}};

        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_outputs_zero",
            64'({RELEASE_ACCESS, DONE, ERROR, ARID, AWID, ARADDR, AWADDR, ARLEN, AWLEN,
                 ARSIZE, AWSIZE, ARBURST, AWBURST, ARVALID, AWVALID, RREADY,
                 WDATA, WLAST, WVALID, BREADY}), 64'd0);
        ARESET = 1;

        // First pass of the table also covers the second-grant ID of 1.
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Read response error on beat 2.
        rresp_err_at = 1;
        run_err_pass("rresp_err");
        rresp_err_at = -1;

        // Early RLAST on beat 3.
        n_rbeats = 3; rlast_at = 2;
        run_err_pass("early_rlast");
        n_rbeats = 4; rlast_at = 3;

        // Write response error, then the next grant clears ERROR.
        bresp_cfg = 2'b10;
        start_grant(2'b00, 8'h02);
        wait_release();
        chk("bresp_err_error", 64'(ERROR), 64'd1);
        chk("bresp_err_data0", 64'(wdata_log[0]), 64'h12);
        exp_id = exp_id + 4'd1;
        bresp_cfg = 2'b00;
        run_vec(vecs[0], "after_bresp");

        // Reset during the second W beat, then a clean pass with ID 0.
        begin
            int t;
            start_grant(2'b00, 8'h02);
            t = 0;
            while (w_cnt < 1 && t < 100) begin @(negedge ACLK); #1; t++; end
            chk("reach_w_beat", 64'(w_cnt >= 1), 64'd1);
            @(negedge ACLK); #2;
            ARESET = 0;
            #1;
            chk("midburst_reset_outputs_zero",
                64'({RELEASE_ACCESS, DONE, ERROR, ARID, AWID, ARADDR, AWADDR, ARLEN, AWLEN,
                     ARSIZE, AWSIZE, ARBURST, AWBURST, ARVALID, AWVALID, RREADY,
                     WDATA, WLAST, WVALID, BREADY}), 64'd0);
            repeat (2) @(negedge ACLK);
            #1;
            ARESET = 1;
            exp_id = '0;
        end
        run_vec(vecs[0], "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_poly_scalar_master.md
# axi4_poly_scalar_master

AXI4 burst master that, on each arbitration grant from the interconnect, reads `NUM_COEF` polynomial coefficients from a slave in one INCR burst. It applies a selectable scalar operation to every coefficient, writes the results back in one INCR burst, checks the write response, then hands the bus back. It is the parametrised successor of the fixed 4×8-bit add-by-2 master: width, depth, IDs, addresses and operation are configurable, and it adds error detection and backpressure-safe handshakes.

## Interface
Parameters:
- `DATA_W`, default 8: coefficient and bus data width. Must be 8, 16 or 32.
- `ADDR_W`, default 5: address width.
- `ID_W`, default 4: transaction ID width.
- `NUM_COEF`, default 4: beats per burst, range 1..16.
- `RD_BASE`, default 0: read burst start address.
- `WR_BASE`, default 0: write burst start address.

Ports:
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESET`  in  1  asynchronous active-low reset.
- `SET_ACCESS`  in  1  interconnect grant.
- `RELEASE_ACCESS`  out  1  one-cycle pulse that returns the grant.
- `OP`  in  2  operation: 00 add, 01 subtract, 10 multiply (low `DATA_W` bits), 11 xor.
- `SCALAR`  in  `DATA_W`  operand.
- `DONE`  out  1  one-cycle pulse at the end of each pass.
- `ERROR`  out  1  sticky error flag for the current or last pass.
- `ARID` / `AWID`  out  `ID_W`  transaction ID, equal to the pass counter.
- `ARADDR` / `AWADDR`  out  `ADDR_W`  `RD_BASE` / `WR_BASE`.
- `ARLEN` / `AWLEN`  out  8  `NUM_COEF`-1.
- `ARSIZE` / `AWSIZE`  out  3  log2(`DATA_W`/8).
- `ARBURST` / `AWBURST`  out  2  01 (INCR).
- `ARVALID` / `AWVALID`  out  1; `ARREADY` / `AWREADY`  in  1.
- `RID` in `ID_W`; `RDATA` in `DATA_W`; `RRESP` in 2; `RLAST` in 1; `RVALID` in 1; `RREADY` out 1.
- `WDATA` out `DATA_W`; `WLAST` out 1; `WVALID` out 1; `WREADY` in 1.
- `BID` in `ID_W`; `BRESP` in 2; `BVALID` in 1; `BREADY` out 1.

## Operation
- States: IDLE, AR, R, CALC, AW, W, B, REL.
- IDLE → AR when `SET_ACCESS`=1.
  - `OP` and `SCALAR` are latched on that edge; `ERROR` clears.
  - `SET_ACCESS` is sampled only in IDLE. Once started, a pass always runs to REL.
- AR: `ARVALID`=1 with all AR fields stable until `ARREADY`. On handshake go to R.
- R: `RREADY`=1. Each `RVALID`&`RREADY` beat stores `RDATA` at buffer index k (0-based), then k increments.
  - `RRESP`≠00 or `RID`≠`ARID` on any beat sets `ERROR`.
  - The burst ends on the beat with `RLAST`=1. `RLAST` on beat k≠`NUM_COEF`-1 sets `ERROR`.
  - Beats beyond `NUM_COEF` are accepted and discarded, and set `ERROR`.
- R end: if `ERROR`=1, go to REL (no write). Otherwise go to CALC.
- CALC: one cycle. All entries are updated in parallel: buf[i] ← buf[i] OP `SCALAR`, truncated modulo 2^`DATA_W` (wrap on overflow and underflow).
- AW: `AWVALID` is held with stable fields until `AWREADY`, then go to W.
- W: `WVALID`=1, `WDATA`=buf[j]. `WLAST`=1 iff j=`NUM_COEF`-1. j advances on each `WREADY`. Go to B after the last beat's handshake.
- B: `BREADY`=1. On `BVALID`: `BRESP`≠00 or `BID`≠`AWID` sets `ERROR`. Go to REL.
- REL: `RELEASE_ACCESS`=1 and `DONE`=1 for exactly one cycle. The ID counter increments, wrapping at 2^`ID_W`. Go to IDLE.
- No VALID output depends combinationally on its READY input. VALID, once raised, stays high until its handshake completes.

## Timing
- Reset (async assert, sync release): state IDLE; buffer, ID counter and every output 0, including `RELEASE_ACCESS`, `DONE`, `ERROR`, all VALID/READY, `ARBURST`/`AWBURST`.
- Reset mid-burst aborts immediately. The next pass restarts with ID 0.
- `ARVALID` is high in the cycle after the grant is sampled.
- With a zero-wait slave, `RELEASE_ACCESS` is high 2·`NUM_COEF`+5 cycles after the grant edge.
- `OP`/`SCALAR` changes after the grant do not affect the current pass.
- `SET_ACCESS` high in the REL cycle is ignored. A new pass starts no earlier than the first IDLE cycle.

## Test plan
- `DATA_W`=8, `NUM_COEF`=4. Slave memory [0x10,0x20,0x30,0xFF], `OP`=00, `SCALAR`=2. Expect writes 0x12,0x22,0x32,0x01, `WLAST` on beat 4, `ERROR`=0, and `RELEASE_ACCESS`/`DONE` pulsing at grant+13. A second grant uses `ARID`=`AWID`=1.
- Same memory with `OP`=01, `SCALAR`=0x11 → writes 0xFF,0x0F,0x1F,0xEE. Then `OP`=10, `SCALAR`=3 → writes 0x30,0x60,0x90,0xFD.
- Slave holds `ARREADY`/`AWREADY` low for 3 cycles and toggles `WREADY`. Expect `ARVALID`/`AWVALID` held with stable address, and `WDATA`/`WLAST` stable while `WREADY`=0. Data as in the first scenario.
- `RRESP`=10 on beat 2, or `RLAST` on beat 3. Expect `ERROR`=1, no `AWVALID` asserted, one `RELEASE_ACCESS` pulse.
- `BRESP`=10 → `ERROR`=1 after B. The next grant clears `ERROR`.
- Assert `ARESET` during beat 2 of W. Expect all outputs 0 immediately. The next grant completes a clean pass with ID 0.
